// File: rtl/spi_flash_read_ctrl.sv
// spi_flash_read_ctrl: SPI mode-3 master issuing AT45DB161D continuous-array reads.
// Shifts {OPCODE, addr} out, then streams rd_len received bytes as one-cycle valid pulses.
module spi_flash_read_ctrl #(
    parameter int         CLK_DIV      = 2,
    parameter int         CS_SETUP_CYC = 1,
    parameter int         CS_HOLD_CYC  = 1,
    parameter int         CS_IDLE_CYC  = 2,
    parameter logic [7:0] OPCODE       = 8'h03,
    parameter int         LEN_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [23:0]      rd_addr,
    input  logic [LEN_W-1:0] rd_len,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_tData,
    output logic             rd_tValid,
    output logic             spi_cs,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso
);
    typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, DATA, CS_HOLD, CS_GAP} state_t;
    localparam logic [15:0] DIV   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP = 16'(CS_SETUP_CYC - 1);
    localparam logic [15:0] HOLD  = 16'(CS_HOLD_CYC - 1);
    localparam logic [15:0] GAP   = 16'(CS_IDLE_CYC - 1);
    state_t           state_q;
    logic [15:0]      cnt_q, div_q;
    logic [LEN_W-1:0] len_q;
    logic [31:0]      tx_q;
    logic [7:0]       rx_q, tdata_q;
    logic [4:0]       bit_q;
    logic             busy_q, done_q, tvalid_q, pend_q, cs_q, sck_q, mosi_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            len_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            tdata_q  <= '0;
            bit_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            pend_q   <= 1'b0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b1;
            mosi_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
            tvalid_q <= pend_q;
            if (pend_q) tdata_q <= rx_q;
            case (state_q)
                IDLE: if (rd_req) begin
                    busy_q <= 1'b1;
                    len_q  <= rd_len;
                    tx_q   <= {OPCODE, rd_addr};
                    if (rd_len != '0) begin
                        cs_q    <= 1'b0;
                        cnt_q   <= SETUP;
                        state_q <= CS_SETUP;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= CS_GAP;
                    end
                end
                CS_SETUP: if (cnt_q == '0) begin
                    sck_q   <= 1'b0;
                    mosi_q  <= tx_q[31];
                    tx_q    <= tx_q << 1;
                    bit_q   <= '0;
                    div_q   <= DIV;
                    state_q <= CMD;
                end else cnt_q <= cnt_q - 16'd1;
                CMD, DATA: begin
                    div_q <= div_q - 16'd1;
                    if (div_q == '0) begin
                        div_q <= DIV;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            if (state_q == DATA) begin
                                rx_q <= {rx_q[6:0], spi_miso};
                                if (bit_q[2:0] == 3'd7) begin
                                    pend_q <= 1'b1;
                                    len_q  <= len_q - LEN_W'(1);
                                    // last byte: leave SCK high and start the CS hold time from this edge
                                    if (len_q == LEN_W'(1)) begin
                                        cnt_q   <= HOLD;
                                        state_q <= CS_HOLD;
                                    end
                                end
                            end
                        end else begin
                            // tx_q is empty once the command is out, so MOSI falls to 0 for DATA
                            sck_q  <= 1'b0;
                            bit_q  <= bit_q + 5'd1;
                            mosi_q <= tx_q[31];
                            tx_q   <= tx_q << 1;
                            if (state_q == CMD && bit_q == 5'd31) state_q <= DATA;
                        end
                    end
                end
                CS_HOLD: if (cnt_q == '0) begin
                    cs_q    <= 1'b1;
                    cnt_q   <= GAP;
                    state_q <= CS_GAP;
                end else cnt_q <= cnt_q - 16'd1;
                CS_GAP: if (cnt_q == '0) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end else cnt_q <= cnt_q - 16'd1;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_tData  = tdata_q;
    assign rd_tValid = tvalid_q;
    assign spi_cs    = cs_q;
    assign spi_clk   = sck_q;
    assign spi_mosi  = mosi_q;
endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// tb_spi_flash_read_ctrl: directed vectors against three DUTs (CLK_DIV 2, 1, 5),
// each with a mode-3 flash slave model and an SCK/CS timing monitor.
module tb_spi_flash_read_ctrl;
    logic clk = 1'b0, reset = 1'b1, clr = 1'b0;
    int cyc = 0, total = 0, bad = 0;
    logic [7:0] sb [16];

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] len;
        logic [31:0] data;
        logic [31:0] cmd;
        logic [15:0] edges;
    } vec_t;
    vec_t vec [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : m
        localparam int D = g == 0 ? 2 : g == 1 ? 1 : 5;
        logic req = 1'b0, miso = 1'b0, cs_p = 1'b1, sck_p = 1'b1;
        logic busy, done, tvalid, cs, sck, mosi;
        logic [15:0] len = '0;
        logic [23:0] addr = '0;
        logic [31:0] cmd = '0;
        logic [7:0] tdata;
        logic [7:0] rx [16];
        int rises, falls, acc_falls, accs, tvs, acc_tvs, dones, bad_sck, bad_space, min_gap;
        int last_tv, first_tv_c, cs_rise_c, cs_fall_c, last_rise_c, done_c, k;
        spi_flash_read_ctrl #(.CLK_DIV(D)) dut (
            .clk(clk), .reset(reset), .rd_addr(addr), .rd_len(len), .rd_req(req),
            .busy(busy), .done(done), .rd_tData(tdata), .rd_tValid(tvalid),
            .spi_cs(cs), .spi_clk(sck), .spi_mosi(mosi), .spi_miso(miso)
        );
        always @(negedge clk) begin
            if (clr) begin
                rises = 0; falls = 0; acc_falls = 0; accs = 0; tvs = 0; acc_tvs = 0;
                dones = 0; bad_sck = 0; bad_space = 0; min_gap = 1000000; cmd = '0;
                cs_rise_c = -1000000; cs_fall_c = 0; last_rise_c = 0; done_c = 0; first_tv_c = 0;
            end else begin
                if (cs_p && !cs) begin
                    accs++; acc_falls = 0; acc_tvs = 0; cs_fall_c = cyc;
                    if (cyc - cs_rise_c < min_gap) min_gap = cyc - cs_rise_c;
                end
                if (!cs_p && cs) cs_rise_c = cyc;
                if (cs && cs_p && sck != sck_p) bad_sck++;
                if (!cs && sck_p && !sck) begin
                    falls++; acc_falls++;
                    if (acc_falls > 32) begin
                        k = acc_falls - 33;
                        miso = sb[4'(k / 8)][3'(7 - k % 8)];
                    end
                end
                if (!cs && !sck_p && sck) begin
                    rises++; last_rise_c = cyc;
                    if (acc_falls <= 32) cmd = {cmd[30:0], mosi};
                end
                if (tvalid) begin
                    if (tvs < 16) rx[4'(tvs)] = tdata;
                    if (acc_tvs == 0) first_tv_c = cyc;
                    else if (cyc - last_tv != 16 * D) bad_space++;
                    last_tv = cyc; tvs++; acc_tvs++;
                end
                if (done) begin dones++; done_c = cyc; end
            end
            cs_p = cs; sck_p = sck;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic clear();
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic start0(input logic [23:0] a, input logic [15:0] l);
        @(negedge clk); #1;
        m[0].addr = a; m[0].len = l; m[0].req = 1'b1;
        @(posedge clk); #1;
        m[0].req = 1'b0;
    endtask

    task automatic wait_done0(input int want);
        int t = 0;
        while (m[0].dones < want && t < 20000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("done0_wait", 32'(m[0].dones >= want), 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) sb[i] = '0;
        vec[0] = '{24'h001234, 16'd4, 32'hA55A00FF, 32'h03001234, 16'd64};
        vec[1] = '{24'hABCDEF, 16'd1, 32'h3C000000, 32'h03ABCDEF, 16'd40};
        vec[2] = '{24'hFFFFFF, 16'd2, 32'h817E0000, 32'h03FFFFFF, 16'd48};
        vec[3] = '{24'h000000, 16'd3, 32'h0180C300, 32'h03000000, 16'd56};
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(m[0].cs), 1);
        chk("rst_sck", 32'(m[0].sck), 1);
        chk("rst_mosi", 32'(m[0].mosi), 0);
        chk("rst_busy", 32'(m[0].busy), 0);
        chk("rst_done", 32'(m[0].done), 0);
        chk("rst_tvalid", 32'(m[0].tvalid), 0);
        chk("rst_tdata", 32'(m[0].tdata), 0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);

        // table-driven accesses on the CLK_DIV=2 instance
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) sb[j] = vec[i].data[31 - 8 * j -: 8];
            clear();
            start0(vec[i].addr, vec[i].len);
            chk("busy_acc", 32'(m[0].busy), 1);
            chk("cs_acc", 32'(m[0].cs), 0);
            wait_done0(1);
            chk("busy_at_done", 32'(m[0].busy), 0);
            chk("cmd", m[0].cmd, vec[i].cmd);
            chk("sck_rises", m[0].rises, 32'(vec[i].edges));
            chk("sck_falls", m[0].falls, 32'(vec[i].edges));
            chk("tvalid_cnt", m[0].tvs, 32'(vec[i].len));
            for (int j = 0; j < 4; j++)
                if (j < vec[i].len) chk("rx_byte", 32'(m[0].rx[j]), 32'(vec[i].data[31 - 8 * j -: 8]));
            chk("first_tv_lat", m[0].first_tv_c - m[0].cs_fall_c, 160);
            chk("byte_spacing", m[0].bad_space, 0);
            chk("cs_hold", m[0].cs_rise_c - m[0].last_rise_c, 1);
            chk("cs_idle", m[0].done_c - m[0].cs_rise_c, 2);
            chk("sck_cs_high", m[0].bad_sck, 0);
            @(negedge clk); #1;
            chk("done_pulse", 32'(m[0].done), 0);
        end

        // zero-length request: no bus activity, done two cycles after request
        clear();
        start0(24'h123456, 16'd0);
        chk("len0_busy", 32'(m[0].busy), 1);
        chk("len0_done_early", 32'(m[0].done), 0);
        @(posedge clk); #1;
        chk("len0_done", 32'(m[0].done), 1);
        chk("len0_busy_end", 32'(m[0].busy), 0);
        chk("len0_cs", 32'(m[0].cs), 1);
        @(negedge clk); #1;
        chk("len0_sck", m[0].rises + m[0].falls + m[0].bad_sck + m[0].accs, 0);

        // request while busy is ignored
        sb[0] = 8'h11; sb[1] = 8'h22; sb[2] = 8'h33; sb[3] = 8'h44;
        clear();
        start0(24'h000100, 16'd4);
        for (int t = 0; t < 5000 && m[0].tvs < 1; t++) begin @(negedge clk); #1; end
        chk("t4_first_byte", m[0].tvs, 1);
        start0(24'hFFFFFF, 16'd2);
        wait_done0(1);
        repeat (20) @(negedge clk);
        #1;
        chk("t4_tvs", m[0].tvs, 4);
        chk("t4_rx3", 32'(m[0].rx[3]), 32'h44);
        chk("t4_cmd", m[0].cmd, 32'h03000100);
        chk("t4_rises", m[0].rises, 64);
        chk("t4_accs", m[0].accs, 1);
        chk("t4_dones", m[0].dones, 1);

        // asynchronous reset during the second byte of an 8-byte read
        for (int j = 0; j < 8; j++) sb[j] = 8'(8'h10 + j);
        clear();
        start0(24'h000200, 16'd8);
        for (int t = 0; t < 5000 && m[0].tvs < 1; t++) begin @(negedge clk); #1; end
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_cs", 32'(m[0].cs), 1);
        chk("t5_sck", 32'(m[0].sck), 1);
        chk("t5_tvalid", 32'(m[0].tvalid), 0);
        chk("t5_busy", 32'(m[0].busy), 0);
        chk("t5_mosi", 32'(m[0].mosi), 0);
        @(negedge clk); #1 reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("t5_tvs", m[0].tvs, 1);
        chk("t5_nodone", m[0].dones, 0);
        sb[0] = 8'h5C; sb[1] = 8'hE7;
        clear();
        start0(24'h000300, 16'd2);
        wait_done0(1);
        chk("t5_cmd", m[0].cmd, 32'h03000300);
        chk("t5_new_tvs", m[0].tvs, 2);
        chk("t5_rx0", 32'(m[0].rx[0]), 32'h5C);
        chk("t5_rx1", 32'(m[0].rx[1]), 32'hE7);

        // back-to-back requests on CLK_DIV=1 and CLK_DIV=5
        sb[0] = 8'hC3; sb[1] = 8'h96;
        clear();
        m[1].addr = 24'h000400; m[1].len = 16'd2; m[1].req = 1'b1;
        m[2].addr = 24'h000400; m[2].len = 16'd2; m[2].req = 1'b1;
        for (int t = 0; t < 5000 && (m[1].req || m[2].req); t++) begin
            @(negedge clk); #1;
            if (m[1].dones >= 2) m[1].req = 1'b0;
            if (m[2].dones >= 2) m[2].req = 1'b0;
        end
        chk("t6_timeout", 32'(m[1].req | m[2].req), 0);
        repeat (5) @(negedge clk);
        #1;
        chk("t6d1_accs", m[1].accs, 2);
        chk("t6d1_tvs", m[1].tvs, 4);
        chk("t6d1_rises", m[1].rises, 96);
        chk("t6d1_cmd", m[1].cmd, 32'h03000400);
        chk("t6d1_rx2", 32'(m[1].rx[2]), 32'hC3);
        chk("t6d1_rx3", 32'(m[1].rx[3]), 32'h96);
        chk("t6d1_space", m[1].bad_space, 0);
        chk("t6d1_gap", 32'(m[1].min_gap >= 2), 1);
        chk("t6d1_sck_cs", m[1].bad_sck, 0);
        chk("t6d5_accs", m[2].accs, 2);
        chk("t6d5_tvs", m[2].tvs, 4);
        chk("t6d5_rises", m[2].rises, 96);
        chk("t6d5_rx0", 32'(m[2].rx[0]), 32'hC3);
        chk("t6d5_rx3", 32'(m[2].rx[3]), 32'h96);
        chk("t6d5_space", m[2].bad_space, 0);
        chk("t6d5_gap", 32'(m[2].min_gap >= 2), 1);
        chk("t6d5_busy", 32'(m[2].busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
